// File: rtl/seq_det_sched_if.sv
// Stream and hit signals of seq_det_sched. The hit_cnt member exists only
// when SEQ_DET_SCHED_STATS_EN is defined.
interface seq_det_sched_if #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
);
  logic [N_CH-1:0] in_vld;
  logic [N_CH-1:0] in_bit;
  logic [N_CH-1:0] in_rdy;
  logic            hit;
  logic [CH_W-1:0] hit_ch;
  logic            busy;
`ifdef SEQ_DET_SCHED_STATS_EN
  logic [7:0]      hit_cnt;
`endif

  modport master (
    output in_vld, output in_bit,
    input  in_rdy, input hit, input hit_ch, input busy
`ifdef SEQ_DET_SCHED_STATS_EN
    , input hit_cnt
`endif
  );

  modport slave (
    input  in_vld, input in_bit,
    output in_rdy, output hit, output hit_ch, output busy
`ifdef SEQ_DET_SCHED_STATS_EN
    , output hit_cnt
`endif
  );
endinterface

// File: rtl/seq_det_sched.sv
// Round-robin time-multiplexed "run of 1s" detector with per-channel run counters.
// Optional saturating hit counter output is enabled by SEQ_DET_SCHED_STATS_EN.
module seq_det_sched #(
  parameter int N_CH    = 4,
  parameter int CH_W    = 2,
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 2
) (
  input logic           ck,
  input logic           r,
  seq_det_sched_if.slave bus
);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
  localparam logic [CH_W-1:0]  PTR_RST = CH_W'(N_CH - 1);

  logic [CH_W-1:0]  ptr;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [N_CH-1:0]  grant;
  logic [CH_W-1:0]  gidx;
  logic             gvalid;
  logic [CNT_W-1:0] curcnt;
  logic             curbit;
  logic [CNT_W-1:0] nxtcnt;
  logic             nxthit;
  logic             hit_q;
  logic [CH_W-1:0]  hit_ch_q;

  // Outer loop walks priority order starting after ptr; the inner loop keeps
  // every channel index constant so no out-of-range select is ever built.
  always_comb begin
    grant  = '0;
    gidx   = '0;
    gvalid = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      for (int j = 0; j < N_CH; j++) begin
        if (!gvalid && bus.in_vld[j] && (j == (int'(ptr) + 1 + k) % N_CH)) begin
          gvalid   = 1'b1;
          gidx     = CH_W'(j);
          grant[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    curcnt = '0;
    curbit = 1'b0;
    for (int j = 0; j < N_CH; j++) begin
      if (grant[j]) begin
        curcnt = cnt[j];
        curbit = bus.in_bit[j];
      end
    end
    if (!curbit)
      nxtcnt = '0;
    else if (curcnt >= RUN_MAX)
      nxtcnt = RUN_MAX;
    else
      nxtcnt = curcnt + 1'b1;
    nxthit = gvalid && (nxtcnt == RUN_MAX);
  end

  always_ff @(posedge ck or posedge r) begin
    if (r) begin
      ptr      <= PTR_RST;
      hit_q    <= 1'b0;
      hit_ch_q <= '0;
      for (int j = 0; j < N_CH; j++)
        cnt[j] <= '0;
    end else begin
      hit_q <= nxthit;
      if (nxthit)
        hit_ch_q <= gidx;
      if (gvalid)
        ptr <= gidx;
      for (int j = 0; j < N_CH; j++)
        if (grant[j])
          cnt[j] <= nxtcnt;
    end
  end

`ifdef SEQ_DET_SCHED_STATS_EN
  logic [7:0] hit_cnt_q;

  always_ff @(posedge ck or posedge r) begin
    if (r)
      hit_cnt_q <= '0;
    else if (nxthit && (hit_cnt_q != 8'hFF))
      hit_cnt_q <= hit_cnt_q + 8'd1;
  end

  assign bus.hit_cnt = hit_cnt_q;
`endif

  assign bus.in_rdy = grant;
  assign bus.busy   = |bus.in_vld;
  assign bus.hit    = hit_q;
  assign bus.hit_ch = hit_ch_q;
endmodule

// File: tb/tb_seq_det_sched.sv
// Randomized and directed bench for seq_det_sched: a run-length reference model
// feeds a scoreboard queue that a separate monitor drains every clock.
module tb_seq_det_sched;
  localparam int N_CH    = 4;
  localparam int CH_W    = 2;
  localparam int RUN_LEN = 2;
  localparam int CNT_W   = 2;

  typedef struct {
    bit hit;
    int ch;
    int cnt;
  } exp_t;

  logic ck = 1'b0;
  logic r  = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  int mPtr;
  int mRun [N_CH];
  int mLastCh;
  int mHitCnt;

  seq_det_sched_if #(.N_CH(N_CH), .CH_W(CH_W)) bus ();

  seq_det_sched #(.N_CH(N_CH), .CH_W(CH_W), .RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
    .ck  (ck),
    .r   (r),
    .bus (bus)
  );

  always #5 ck = ~ck;

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pickChannel(input logic [N_CH-1:0] v);
    for (int k = 1; k <= N_CH; k++) begin
      int c;
      c = (mPtr + k) % N_CH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mPtr    = N_CH - 1;
    mLastCh = 0;
    mHitCnt = 0;
    for (int i = 0; i < N_CH; i++) mRun[i] = 0;
  endtask

  // One cycle: drive inputs, check the combinational grant, advance the model
  // and queue the registered response expected after the coming edge.
  task automatic applyStimulus(input logic [N_CH-1:0] vld, input logic [N_CH-1:0] bits,
                               output int granted);
    exp_t e;
    int   g;
    @(negedge ck);
    bus.in_vld = vld;
    bus.in_bit = bits;
    #1;
    g = pickChannel(vld);
    checkOutput("in_rdy", int'(bus.in_rdy), (g >= 0) ? (1 << g) : 0);
    checkOutput("busy", int'(bus.busy), (vld != '0) ? 1 : 0);
    e.hit = 1'b0;
    if (g >= 0) begin
      mPtr    = g;
      mRun[g] = bits[g] ? mRun[g] + 1 : 0;
      if (mRun[g] >= RUN_LEN) begin
        e.hit   = 1'b1;
        mLastCh = g;
        if (mHitCnt < 255) mHitCnt++;
      end
    end
    e.ch  = mLastCh;
    e.cnt = mHitCnt;
    sb.push_back(e);
    granted = g;
  endtask

  task automatic doReset();
    @(negedge ck);
    r = 1'b1;
    bus.in_vld = '0;
    bus.in_bit = '0;
    sb.delete();
    modelReset();
    #1;
    checkOutput("reset hit", int'(bus.hit), 0);
    checkOutput("reset hit_ch", int'(bus.hit_ch), 0);
    checkOutput("reset in_rdy", int'(bus.in_rdy), 0);
`ifdef SEQ_DET_SCHED_STATS_EN
    checkOutput("reset hit_cnt", int'(bus.hit_cnt), 0);
`endif
    @(negedge ck);
    r = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge ck);
      #1;
      if (!r && sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("hit", int'(bus.hit), int'(e.hit));
        checkOutput("hit_ch", int'(bus.hit_ch), e.ch);
`ifdef SEQ_DET_SCHED_STATS_EN
        checkOutput("hit_cnt", int'(bus.hit_cnt), e.cnt);
`endif
      end
    end
  end

  initial begin : stimulus
    int g;
    logic [N_CH-1:0] vld, bits, prevVld, prevBits, prevGrant;
    logic [5:0] ch0Seq;
    bus.in_vld = '0;
    bus.in_bit = '0;
    modelReset();
    doReset();

    // Lone channel 0 stream 0,1,1,1,0,1
    ch0Seq = 6'b101110;
    for (int i = 0; i < 6; i++) applyStimulus(4'b0001, {3'b000, ch0Seq[i]}, g);
    applyStimulus(4'b0000, 4'b0000, g);

    // Everyone valid, all ones: rotation then a hit every cycle
    doReset();
    for (int i = 0; i < 12; i++) applyStimulus(4'b1111, 4'b1111, g);

    // Isolation: ch1 one, ch2 zero, ch1 one
    doReset();
    applyStimulus(4'b0010, 4'b0010, g);
    applyStimulus(4'b0100, 4'b0000, g);
    applyStimulus(4'b0010, 4'b0010, g);
    applyStimulus(4'b0100, 4'b0100, g);
    applyStimulus(4'b0000, 4'b0000, g);

    // Wrap-around skip from ptr=1
    doReset();
    applyStimulus(4'b0010, 4'b0000, g);
    applyStimulus(4'b0001, 4'b0000, g);
    applyStimulus(4'b1001, 4'b1000, g);
    applyStimulus(4'b0000, 4'b0000, g);

    // Reset discards a partial run on ch3
    applyStimulus(4'b1000, 4'b1000, g);
    doReset();
    applyStimulus(4'b1000, 4'b1000, g);
    applyStimulus(4'b1000, 4'b1000, g);
    applyStimulus(4'b0000, 4'b0000, g);

    // Long all-ones burst drives the hit counter past saturation
    doReset();
    for (int i = 0; i < 320; i++) applyStimulus(4'b1111, 4'b1111, g);
    doReset();

    // Random traffic; a waiting channel keeps its bit and stays valid
    prevVld = '0; prevBits = '0; prevGrant = '0;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (prevVld[c] && !prevGrant[c]) begin
          vld[c]  = 1'b1;
          bits[c] = prevBits[c];
        end else begin
          vld[c]  = ($urandom_range(0, 9) < 6);
          bits[c] = ($urandom_range(0, 3) != 0);
        end
      end
      applyStimulus(vld, bits, g);
      prevVld   = vld;
      prevBits  = bits;
      prevGrant = (g >= 0) ? N_CH'(1 << g) : '0;
      if (i == 200) begin
        doReset();
        prevVld = '0;
      end
    end
    applyStimulus(4'b0000, 4'b0000, g);

    @(posedge ck);
    #2;
    checkOutput("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
